// File: rtl/entry2c_pkg.sv
// Shared types and constants for the decimal-entry to two's-complement converter.
package entry2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    MUL,
    ADD,
    COMMIT
  } state_e;

  localparam int unsigned ACC_W   = 10;
  localparam logic [ACC_W-1:0] ACC_MAX = 10'd1023;

  // Largest positive magnitude representable in a w-bit two's-complement word.
  function automatic logic [31:0] MAX_POS(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Largest negative magnitude representable in a w-bit two's-complement word.
  function automatic logic [31:0] MAX_NEG_MAG(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/entry2c_sat_mac10.sv
// Combinational saturating acc*10 and acc+digit for the 10-bit entry accumulator.
module sat_mac10
  import entry2c_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [ACC_W-1:0] mul_o,
  output logic             mul_sat_o,
  output logic [ACC_W-1:0] add_o,
  output logic             add_sat_o
);

  logic [13:0] mul_full;
  logic [10:0] add_full;

  // acc*10 as (acc<<3)+(acc<<1), and acc+digit, each clamped at ACC_MAX.
  always_comb begin
    mul_full  = 14'({acc_i, 3'b000}) + 14'({acc_i, 1'b0});
    mul_sat_o = (mul_full > 14'(ACC_MAX));
    mul_o     = mul_sat_o ? ACC_MAX : mul_full[ACC_W-1:0];
    add_full  = 11'(acc_i) + 11'(digit_i);
    add_sat_o = (add_full > 11'(ACC_MAX));
    add_o     = add_sat_o ? ACC_MAX : add_full[ACC_W-1:0];
  end

endmodule

// File: rtl/entry2c.sv
// Decimal-entry to two's-complement converter: accumulates BCD digits and a
// sign flag, and on enter commits a range-checked W-bit word.
module entry2c
  import entry2c_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic             neg_toggle,
  input  logic             enter,
  input  logic             clear,
  output logic [W-1:0]     dout,
  output logic             dout_valid,
  output logic             overflow,
  output logic             neg,
  output logic [ACC_W-1:0] mag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sticky_q, sticky_d;
  logic [3:0]       digit_q, digit_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             dv_q, dv_d;

  logic [ACC_W-1:0] mul_val, add_val;
  logic             mul_sat, add_sat;
  logic [W-1:0]     acc_w;
  logic             range_ovf;

  sat_mac10 u_mac (
    .acc_i     (acc_q),
    .digit_i   (digit_q),
    .mul_o     (mul_val),
    .mul_sat_o (mul_sat),
    .add_o     (add_val),
    .add_sat_o (add_sat)
  );

  // Range check against the sign-dependent limit and the low W bits of the magnitude.
  always_comb begin
    acc_w     = W'(acc_q);
    range_ovf = sticky_q
             || (!neg_q && (32'(acc_q) > MAX_POS(W)))
             || ( neg_q && (32'(acc_q) > MAX_NEG_MAG(W)));
  end

  // State and datapath registers; reset discards any partial entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sticky_q <= 1'b0;
      digit_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sticky_q <= sticky_d;
      digit_q  <= digit_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      dv_q     <= dv_d;
    end
  end

  // Next-state logic: clear > enter > digit; a same-cycle sign toggle lands before COMMIT samples it.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sticky_d = sticky_q;
    digit_d  = digit_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    dv_d     = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = 1'b0;
      sticky_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ENTRY: begin
          if (neg_toggle) neg_d = !neg_q;
          if (enter) begin
            state_d = COMMIT;
          end else if (digit_valid && (digit_in <= 4'd9)) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              sticky_d = 1'b1;
            end else begin
              digit_d = digit_in;
              state_d = MUL;
            end
          end
        end
        MUL: begin
          if (neg_toggle) neg_d = !neg_q;
          acc_d    = mul_val;
          sticky_d = sticky_q | mul_sat;
          state_d  = ADD;
        end
        ADD: begin
          if (neg_toggle) neg_d = !neg_q;
          acc_d    = add_val;
          sticky_d = sticky_q | add_sat;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = ENTRY;
        end
        COMMIT: begin
          ovf_d    = range_ovf;
          dout_d   = range_ovf ? '0 : (neg_q ? (~acc_w + W'(1)) : acc_w);
          dv_d     = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = 1'b0;
          sticky_d = 1'b0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign digit_ready = (state_q == IDLE) || (state_q == ENTRY);
  assign busy        = (state_q == MUL) || (state_q == ADD) || (state_q == COMMIT);
  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign overflow    = ovf_q;
  assign neg         = neg_q;
  assign mag         = acc_q;

endmodule

// File: tb/tb_entry2c.sv
// Scoreboard bench for entry2c: stimulus queues expected commits, a monitor checks them.
module tb_entry2c;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic       neg_toggle = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       overflow;
  logic       neg;
  logic [9:0] mag;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_dv_cyc = 0;
  int pulses = 0;
  int enters = 0;
  logic prev_dv = 1'b0;
  logic [8:0] exp_q[$];

  entry2c #(.W(8), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .neg_toggle(neg_toggle), .enter(enter),
    .clear(clear), .dout(dout), .dout_valid(dout_valid), .overflow(overflow),
    .neg(neg), .mag(mag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every dout_valid pulse.
  always @(negedge clk) begin
    if (dout_valid) begin
      pulses++;
      last_dv_cyc = cyc;
      check("dv_single_pulse", int'(prev_dv), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("dout", int'(dout), int'(e[7:0]));
        check("overflow", int'(overflow), int'(e[8]));
      end
    end
    prev_dv = dout_valid;
  end

  // Present a digit and hold it until the DUT consumes it; returns the consuming cycle.
  task automatic send_digit(input logic [3:0] d, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    digit_in = d;
    digit_valid = 1'b1;
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("digit_timeout", 1, 0);
    @(negedge clk);
    acc_cyc = cyc;
    digit_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 1, 0);
  endtask

  task automatic do_enter(input logic [7:0] ed, input logic eo, input logic tog);
    wait_ready();
    exp_q.push_back({eo, ed});
    enters++;
    enter = 1'b1;
    neg_toggle = tog;
    @(negedge clk);
    enter = 1'b0;
    neg_toggle = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic toggle();
    @(negedge clk);
    neg_toggle = 1'b1;
    @(negedge clk);
    neg_toggle = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int c0, c;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_dv", int'(dout_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_neg", int'(neg), 0);
    check("rst_mag", int'(mag), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", int'(digit_ready), 1);
    check("rst_busy", int'(busy), 0);

    // 127 with latency check
    send_digit(4'd1, c0);
    check("busy_in_mul", int'(busy), 1);
    check("ready_in_mul", int'(digit_ready), 0);
    send_digit(4'd2, c);
    send_digit(4'd7, c);
    do_enter(8'h7F, 1'b0, 1'b0);
    check("latency", last_dv_cyc - c0, 10);

    // -128 legal, +128 overflows
    send_digit(4'd1, c);
    send_digit(4'd2, c);
    send_digit(4'd8, c);
    toggle();
    check("neg_live", int'(neg), 1);
    do_enter(8'h80, 1'b0, 1'b0);
    send_digit(4'd1, c);
    send_digit(4'd2, c);
    send_digit(4'd8, c);
    do_enter(8'h00, 1'b1, 1'b0);

    // Sign handling
    toggle();
    send_digit(4'd5, c);
    do_enter(8'hFB, 1'b0, 1'b0);
    send_digit(4'd4, c);
    toggle();
    toggle();
    do_enter(8'h04, 1'b0, 1'b0);
    send_digit(4'd5, c);
    do_enter(8'hFB, 1'b0, 1'b1);   // toggle concurrent with enter
    do_enter(8'h00, 1'b0, 1'b1);   // -0

    // Digit limit, sticky overflow, illegal digit
    send_digit(4'd9, c);
    send_digit(4'd9, c);
    send_digit(4'd9, c);
    repeat (2) @(negedge clk);
    check("mag_999", int'(mag), 999);
    digit_in = 4'd12;
    digit_valid = 1'b1;
    repeat (4) @(negedge clk);
    digit_valid = 1'b0;
    check("mag_after_illegal", int'(mag), 999);
    check("ready_after_illegal", int'(digit_ready), 1);
    send_digit(4'd9, c);
    check("mag_after_discard", int'(mag), 999);
    check("ready_after_discard", int'(digit_ready), 1);
    do_enter(8'h00, 1'b1, 1'b0);

    // Clear, then empty entry
    send_digit(4'd4, c);
    send_digit(4'd2, c);
    repeat (2) @(negedge clk);
    check("mag_42", int'(mag), 42);
    do_clear();
    check("mag_cleared", int'(mag), 0);
    check("dout_after_clear", int'(dout), 0);
    send_digit(4'd3, c);
    do_enter(8'h03, 1'b0, 1'b0);
    do_enter(8'h00, 1'b0, 1'b0);

    // Reset mid-entry
    send_digit(4'd5, c);
    do_enter(8'h05, 1'b0, 1'b0);
    toggle();
    send_digit(4'd2, c);
    send_digit(4'd6, c);
    rst = 1'b1;
    #1;
    check("midrst_neg", int'(neg), 0);
    check("midrst_mag", int'(mag), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", int'(digit_ready), 1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pulse_count", pulses, enters);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
